mgt_01_reg_file_sb: RTL

Parametrised register file with an integrated write-pending scoreboard for the MGT-01 RV32IMF core. One instance serves the integer file (reg 0 hardwired to zero) and one serves the FP file (all registers writable). Two write ports are provided: port A for the in-order writeback stage and port B for long-latency units (divider, FPU, LSU misses). Per-register busy bits let decode stall on RAW hazards against outstanding long-latency results.

---
 rtl/mgt_01_pkg.sv | 30 +++
 rtl/mgt_01_scoreboard.sv | 69 ++++++
 rtl/mgt_01_reg_file_sb.sv | 104 ++++++++++
 3 files changed

// File: rtl/mgt_01_pkg.sv
// Shared types and defaults for the MGT-01 register files.
package mgt_01_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;

    typedef logic [DATA_W_DEF-1:0] data_bus_t;

    // Integer register ABI names
    typedef enum logic [4:0] {
        I_ZERO, I_RA, I_SP, I_GP, I_TP, I_T0, I_T1, I_T2,
        I_S0, I_S1, I_A0, I_A1, I_A2, I_A3, I_A4, I_A5,
        I_A6, I_A7, I_S2, I_S3, I_S4, I_S5, I_S6, I_S7,
        I_S8, I_S9, I_S10, I_S11, I_T3, I_T4, I_T5, I_T6
    } i_register_e;

    // Floating-point register ABI names
    typedef enum logic [4:0] {
        F_FT0, F_FT1, F_FT2, F_FT3, F_FT4, F_FT5, F_FT6, F_FT7,
        F_FS0, F_FS1, F_FA0, F_FA1, F_FA2, F_FA3, F_FA4, F_FA5,
        F_FA6, F_FA7, F_FS2, F_FS3, F_FS4, F_FS5, F_FS6, F_FS7,
        F_FS8, F_FS9, F_FS10, F_FS11, F_FT8, F_FT9, F_FT10, F_FT11
    } f_register_e;

    // Width of a counter able to hold 0..n inclusive
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mgt_01_scoreboard.sv
// Write-pending scoreboard: busy bit per register, issue/completion
// arbitration and a running count of busy registers.
module mgt_01_scoreboard
    import mgt_01_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(NUM_REGS),
    localparam int CW = count_w(NUM_REGS)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                clr_en_i,
    input  logic [AW-1:0]       clr_addr_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                iss_ready_o,
    output logic [CW-1:0]       pending_o
);

    logic [NUM_REGS-1:0] r_busy;
    logic [CW-1:0]       r_pending;
    logic                w_iss_zero;
    logic                w_clr_same;
    logic                w_iss_acc;
    logic                w_clr_eff;
    logic [NUM_REGS-1:0] w_iss_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    // Issue readiness is judged against the post-completion state, so a
    // completion and a re-issue to the same register can share a cycle.
    assign w_iss_zero  = (ZERO_REG != 0) && (iss_addr_i == '0);
    assign w_clr_same  = clr_en_i && (clr_addr_i == iss_addr_i);
    assign iss_ready_o = w_iss_zero || !r_busy[iss_addr_i] || w_clr_same;
    assign w_iss_acc   = iss_en_i && iss_ready_o && !w_iss_zero;
    assign w_clr_eff   = clr_en_i && r_busy[clr_addr_i];

    // One-hot set/clear masks for this cycle's accepted events
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_iss_mask = '0;
        w_clr_mask = '0;
        if (w_iss_acc) w_iss_mask[iss_addr_i] = 1'b1;
        if (w_clr_eff) w_clr_mask[clr_addr_i] = 1'b1;
    end

    // Busy vector and popcount tracker; issue wins over a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_busy <= (r_busy & ~w_clr_mask) | w_iss_mask;
            case ({w_iss_acc, w_clr_eff})
                2'b10:   r_pending <= r_pending + CW'(1);
                2'b01:   r_pending <= r_pending - CW'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign pending_o = r_pending;

endmodule

// File: rtl/mgt_01_reg_file_sb.sv
// MGT-01 register file with write-pending scoreboard.
// Optional macro MGT_01_RF_BYPASS_EN: write-first forwarding of same-cycle
// writes (A over B) and of a same-cycle B busy clear onto the read ports.
module mgt_01_reg_file_sb
    import mgt_01_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(NUM_REGS),
    localparam int CW = count_w(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_RD*AW-1:0]     raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    output logic [NUM_RD-1:0]        rbusy_o,
    input  logic                     wa_en_i,
    input  logic [AW-1:0]            wa_addr_i,
    input  logic [DATA_W-1:0]        wa_data_i,
    input  logic                     wb_en_i,
    input  logic [AW-1:0]            wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     iss_en_i,
    input  logic [AW-1:0]            iss_addr_i,
    output logic                     iss_ready_o,
    output logic [CW-1:0]            pending_o,
    output logic                     collide_o
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_collide;
    logic [NUM_REGS-1:0] w_busy;
    logic                w_wa_we;
    logic                w_wb_we;

    // Writes aimed at a hardwired zero register are simply discarded
    assign w_wa_we = wa_en_i && !((ZERO_REG != 0) && (wa_addr_i == '0));
    assign w_wb_we = wb_en_i && !((ZERO_REG != 0) && (wb_addr_i == '0));

    mgt_01_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .iss_en_i    (iss_en_i),
        .iss_addr_i  (iss_addr_i),
        .clr_en_i    (wb_en_i),
        .clr_addr_i  (wb_addr_i),
        .busy_o      (w_busy),
        .iss_ready_o (iss_ready_o),
        .pending_o   (pending_o)
    );

    // Storage: B written first so a same-address A write lands last and wins
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: the array is reset because software relies on every
            // register reading zero after reset; this forces flops, not RAM.
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_wb_we) r_regs[wb_addr_i] <= wb_data_i;
            if (w_wa_we) r_regs[wa_addr_i] <= wa_data_i;
        end
    end

    // Flag a same-register A/B write for exactly one cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_collide <= 1'b0;
        end else begin
            r_collide <= w_wa_we && w_wb_we && (wa_addr_i == wb_addr_i);
        end
    end

    assign collide_o = r_collide;

    // Read ports: stored state, optional write-first forwarding, zero override
    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [AW-1:0] w_ra;
            w_ra = raddr_i[k*AW +: AW];
            rdata_o[k*DATA_W +: DATA_W] = r_regs[w_ra];
            rbusy_o[k]                  = w_busy[w_ra];
`ifdef MGT_01_RF_BYPASS_EN
            if (wa_en_i && (wa_addr_i == w_ra)) begin
                rdata_o[k*DATA_W +: DATA_W] = wa_data_i;
            end else if (wb_en_i && (wb_addr_i == w_ra)) begin
                rdata_o[k*DATA_W +: DATA_W] = wb_data_i;
            end
            if (wb_en_i && (wb_addr_i == w_ra)) rbusy_o[k] = 1'b0;
`endif
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                rdata_o[k*DATA_W +: DATA_W] = '0;
                rbusy_o[k]                  = 1'b0;
            end
        end
    end

endmodule
